// File: rtl/scope_trigger_ctrl.sv
// scope_trigger_ctrl
// Trigger and sequencing controller for the oscilloscope capture path.
// Watches the raw signed sample stream, decides when a capture starts
// (level/slope trigger, optional auto timeout, single-shot), decimates the
// stream into a bounded burst of DEPTH write strobes, then waits for the
// display to go idle before pulsing the buffer swap.
//
// Build option: define TRIG_AUTO_EN to build the auto-trigger timeout
// (mode 1). Without it, mode 1 behaves as normal and auto_fired is 0.
`default_nettype none

module scope_trigger_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int HOLDOFF_W    = 16,
  parameter int AUTO_SAMPLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_sample_ready,
  input  logic signed [15:0]       new_sample_in,
  input  logic signed [15:0]       trig_level,
  input  logic                     trig_slope,
  input  logic [1:0]               mode,
  input  logic [3:0]               decim,
  input  logic [HOLDOFF_W-1:0]     holdoff,
  input  logic                     arm,
  input  logic                     display_idle,
  output logic                     cap_strobe,
  output logic [7:0]               cap_data,
  output logic [ADDR_W-1:0]        cap_index,
  output logic                     swap,
  output logic                     auto_fired,
  output logic [2:0]               state
);

  localparam int DATA_W = 16;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // Offset-binary conversion of the sample's top byte (adds mid-scale).
  function automatic logic [7:0] offset_bin(input logic signed [DATA_W-1:0] s);
    return s[DATA_W-1 -: 8] + 8'd128;
  endfunction

  state_t                   state_q;
  state_t                   state_d;

  logic signed [DATA_W-1:0] prev_p0;
  logic                     prev_vld_p0;

  logic [3:0]               dcnt_q;
  logic [ADDR_W-1:0]        index_q;
  logic [HOLDOFF_W-1:0]     hcnt_q;
  logic [HOLDOFF_W:0]       hcnt_inc;
  logic                     hold_done;

  logic                     below_prev;
  logic                     below_cur;
  logic                     trig_hit;
  logic                     auto_hit;
  logic                     fire;
  logic                     take;
  logic                     last_idx;

  logic                     emit;
  logic [ADDR_W-1:0]        emit_idx;
  logic                     swap_d;

  logic                     vld_p1;
  logic [7:0]               data_p1;
  logic [ADDR_W-1:0]        index_p1;
  logic                     swap_p1;

  // ---- stage p0: raw sample compare against threshold ----
  assign below_prev = prev_p0 < trig_level;
  assign below_cur  = new_sample_in < trig_level;
  assign trig_hit   = new_sample_ready && prev_vld_p0 &&
                      (trig_slope ? (!below_prev && below_cur)
                                  : (below_prev && !below_cur));
  assign fire       = trig_hit || auto_hit;
  assign take       = new_sample_ready && (dcnt_q == 4'd0);
  assign last_idx   = (index_q == {ADDR_W{1'b1}});
  assign hcnt_inc   = {1'b0, hcnt_q} + (HOLDOFF_W+1)'(1);
  assign hold_done  = (hcnt_inc >= {1'b0, holdoff});

`ifdef TRIG_AUTO_EN
  localparam int                ACNT_W    = $clog2(AUTO_SAMPLES + 1);
  localparam logic [ACNT_W-1:0] AUTO_MAX  = ACNT_W'(AUTO_SAMPLES);
  localparam logic [ACNT_W-1:0] AUTO_LAST = ACNT_W'(AUTO_SAMPLES - 1);
  localparam logic [1:0]        MODE_AUTO = 2'd1;

  logic [ACNT_W-1:0] acnt_q;
  logic              auto_q;

  // The sample that brings the ARMED count to AUTO_SAMPLES forces a trigger.
  assign auto_hit   = new_sample_ready && (state_q == ST_ARMED) &&
                      (mode == MODE_AUTO) && (acnt_q >= AUTO_LAST);
  assign auto_fired = auto_q;

  // Count raw samples spent in ARMED, saturating; cleared outside ARMED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt_q <= '0;
    end else if (state_q != ST_ARMED) begin
      acnt_q <= '0;
    end else if (new_sample_ready && (acnt_q != AUTO_MAX)) begin
      acnt_q <= acnt_q + ACNT_W'(1);
    end
  end

  // Remember whether the capture just started was forced (a level hit wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b0;
    end else if ((state_q == ST_ARMED) && fire) begin
      auto_q <= !trig_hit;
    end
  end
`else
  assign auto_hit   = 1'b0;
  assign auto_fired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((mode != MODE_SINGLE) || arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (fire) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (take && last_idx) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (display_idle) state_d = (mode == MODE_SINGLE) ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if ((holdoff == '0) || (new_sample_ready && hold_done)) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: which sample is emitted, at which index, and swap request.
  always_comb begin
    emit     = 1'b0;
    emit_idx = index_q;
    swap_d   = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (fire) begin
          emit     = 1'b1;
          emit_idx = '0;
        end
      end
      ST_CAPTURE: begin
        emit = take;
      end
      ST_WAIT: begin
        swap_d = display_idle;
      end
      default: ;
    endcase
  end

  // Previous raw sample, tracked in every state; invalid until first sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_p0     <= '0;
      prev_vld_p0 <= 1'b0;
    end else if (new_sample_ready) begin
      prev_p0     <= new_sample_in;
      prev_vld_p0 <= 1'b1;
    end
  end

  // Decimation and write-index counters; decim is picked up at each reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_q  <= 4'd0;
      index_q <= '0;
    end else if (emit) begin
      dcnt_q  <= decim;
      index_q <= emit_idx + ADDR_W'(1);
    end else if ((state_q == ST_CAPTURE) && new_sample_ready) begin
      dcnt_q  <= dcnt_q - 4'd1;
    end
  end

  // Holdoff sample counter, only live while in HOLDOFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
    end else if (state_q != ST_HOLDOFF) begin
      hcnt_q <= '0;
    end else if (new_sample_ready) begin
      hcnt_q <= hcnt_inc[HOLDOFF_W-1:0];
    end
  end

  // ---- stage p1: registered strobe, data, index and swap pulse ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      data_p1  <= 8'd0;
      index_p1 <= '0;
      swap_p1  <= 1'b0;
    end else begin
      vld_p1  <= emit;
      swap_p1 <= swap_d;
      if (emit) begin
        data_p1  <= offset_bin(new_sample_in);
        index_p1 <= emit_idx;
      end
    end
  end

  assign cap_strobe = vld_p1;
  assign cap_data   = data_p1;
  assign cap_index  = index_p1;
  assign swap       = swap_p1;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_scope_trigger_ctrl.sv
// tb_scope_trigger_ctrl
// Directed bench for scope_trigger_ctrl. Expected strobes and swap pulses
// are queued as stimulus is issued; a negedge monitor pops and compares
// whenever the DUT presents either. State/flag checks are made inline.
module tb_scope_trigger_ctrl;

  logic               clk;
  logic               reset;
  logic               new_sample_ready;
  logic signed [15:0] new_sample_in;
  logic signed [15:0] trig_level;
  logic               trig_slope;
  logic [1:0]         mode;
  logic [3:0]         decim;
  logic [15:0]        holdoff;
  logic               arm;
  logic               display_idle;
  logic               cap_strobe;
  logic [7:0]         cap_data;
  logic [7:0]         cap_index;
  logic               swap;
  logic               auto_fired;
  logic [2:0]         state;

  typedef struct packed {
    logic       is_swap;
    logic [7:0] idx;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_vec;
  int  n_err;

  scope_trigger_ctrl #(
    .ADDR_W      (8),
    .HOLDOFF_W   (16),
    .AUTO_SAMPLES(4096)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .new_sample_ready(new_sample_ready),
    .new_sample_in   (new_sample_in),
    .trig_level      (trig_level),
    .trig_slope      (trig_slope),
    .mode            (mode),
    .decim           (decim),
    .holdoff         (holdoff),
    .arm             (arm),
    .display_idle    (display_idle),
    .cap_strobe      (cap_strobe),
    .cap_data        (cap_data),
    .cap_index       (cap_index),
    .swap            (swap),
    .auto_fired      (auto_fired),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, %0d events still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Offset binary of the top byte: adding 128 mod 256 flips the MSB.
  function automatic logic [7:0] exp_data(input logic signed [15:0] v);
    return v[15:8] ^ 8'h80;
  endfunction

  task automatic push_strobe(input int idx, input logic signed [15:0] v);
    ev_t e;
    e.is_swap = 1'b0;
    e.idx     = 8'(idx);
    e.data    = exp_data(v);
    exp_q.push_back(e);
  endtask

  task automatic push_swap();
    ev_t e;
    e.is_swap = 1'b1;
    e.idx     = 8'd0;
    e.data    = 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic smp(input logic signed [15:0] v);
    new_sample_ready = 1'b1;
    new_sample_in    = v;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic do_swap();
    push_swap();
    display_idle = 1'b1;
    idle(1);
    display_idle = 1'b0;
  endtask

  // Monitor: every strobe or swap must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && (cap_strobe || swap)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: strobe=%0b swap=%0b idx=%0d data=%02h, expected none",
                 cap_strobe, swap, cap_index, cap_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.is_swap != swap) || (mon_e.is_swap == cap_strobe) ||
            (!mon_e.is_swap && ((mon_e.idx != cap_index) || (mon_e.data != cap_data)))) begin
          n_err++;
          $display("FAIL event: got strobe=%0b swap=%0b idx=%0d data=%02h, expected swap=%0b idx=%0d data=%02h",
                   cap_strobe, swap, cap_index, cap_data, mon_e.is_swap, mon_e.idx, mon_e.data);
        end
      end
    end
  end

  initial begin
    logic signed [15:0] v;
    n_vec = 0;
    n_err = 0;
    reset            = 1'b1;
    new_sample_ready = 1'b0;
    new_sample_in    = '0;
    trig_level       = 16'sd0;
    trig_slope       = 1'b0;
    mode             = 2'd0;
    decim            = 4'd0;
    holdoff          = 16'd0;
    arm              = 1'b0;
    display_idle     = 1'b0;
    idle(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_strobe", 32'(cap_strobe), 0);
    chk("rst_data", 32'(cap_data), 0);
    chk("rst_index", 32'(cap_index), 0);
    chk("rst_swap", 32'(swap), 0);
    chk("rst_auto", 32'(auto_fired), 0);
    reset = 1'b0;
    idle(1);
    chk("idle_to_armed", 32'(state), 1);

    // Normal rising trigger at level 0, decim 0, holdoff 0.
    smp(-16'sd100);
    chk("first_sample_no_trig", 32'(state), 1);
    push_strobe(0, 16'sd100);
    smp(16'sd100);
    chk("rise_trig", 32'(state), 2);
    chk("rise_auto_flag", 32'(auto_fired), 0);
    for (int i = 1; i < 256; i++) begin
      v = 16'(i * 211 - 20000);
      push_strobe(i, v);
      smp(v);
      if (i % 50 == 0) idle(1);
    end
    chk("rise_wait", 32'(state), 3);
    smp(-16'sd50);
    idle(2);
    chk("wait_holds", 32'(state), 3);
    do_swap();
    chk("swap_to_holdoff", 32'(state), 4);
    idle(1);
    chk("holdoff0_armed", 32'(state), 1);

    // Falling trigger at level 1000, then a decim-3 capture.
    trig_slope = 1'b1;
    trig_level = 16'sd1000;
    smp(16'sd500);
    smp(16'sd2000);
    chk("fall_no_trig", 32'(state), 1);
    decim = 4'd3;
    push_strobe(0, 16'sd500);
    smp(16'sd500);
    chk("fall_trig", 32'(state), 2);
    for (int k = 1; k <= 1020; k++) begin
      v = 16'(k * 97 - 30000);
      if (k % 4 == 0) push_strobe(k / 4, v);
      smp(v);
      if (k == 1019) chk("decim_still_capture", 32'(state), 2);
    end
    chk("decim_wait", 32'(state), 3);
    holdoff = 16'd10;
    do_swap();
    chk("holdoff_enter", 32'(state), 4);
    for (int k = 1; k <= 10; k++) begin
      smp((k % 2 == 1) ? 16'sd2000 : 16'sd500);
      if (k == 9) chk("holdoff_9", 32'(state), 4);
    end
    chk("holdoff_done", 32'(state), 1);

    // Single-shot: one capture, swap, back to IDLE until arm.
    mode       = 2'd2;
    trig_slope = 1'b0;
    trig_level = 16'sd0;
    decim      = 4'd0;
    holdoff    = 16'd0;
    smp(-16'sd10);
    push_strobe(0, 16'sd10);
    smp(16'sd10);
    chk("single_trig", 32'(state), 2);
    for (int i = 1; i < 256; i++) begin
      v = 16'(500 - i * 129);
      push_strobe(i, v);
      smp(v);
    end
    chk("single_wait", 32'(state), 3);
    smp(-16'sd10);
    do_swap();
    chk("single_idle", 32'(state), 0);
    smp(16'sd10);
    smp(-16'sd10);
    smp(16'sd10);
    idle(1);
    chk("single_stays_idle", 32'(state), 0);
    arm = 1'b1;
    idle(1);
    arm = 1'b0;
    chk("arm_to_armed", 32'(state), 1);

    // Capture interrupted by reset right after index 100 is strobed.
    smp(-16'sd20);
    push_strobe(0, 16'sd20);
    smp(16'sd20);
    for (int i = 1; i <= 100; i++) begin
      v = (i == 100) ? -16'sd700 : 16'(i * 300);
      if (i < 100) push_strobe(i, v);
      smp(v);
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_strobe", 32'(cap_strobe), 0);
    chk("rst_mid_index", 32'(cap_index), 0);
    chk("rst_mid_data", 32'(cap_data), 0);
    chk("rst_mid_state", 32'(state), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("post_rst_single_idle", 32'(state), 0);
    mode = 2'd0;
    idle(1);
    chk("post_rst_armed", 32'(state), 1);
    smp(16'sd700);
    chk("prev_invalid_no_trig", 32'(state), 1);
    smp(-16'sd700);
    push_strobe(0, 16'sd700);
    smp(16'sd700);
    chk("post_rst_trig", 32'(state), 2);
    for (int i = 1; i < 256; i++) begin
      v = 16'(i * 55);
      push_strobe(i, v);
      smp(v);
    end
    chk("post_rst_wait", 32'(state), 3);
    do_swap();
    idle(1);
    chk("post_rst_rearmed", 32'(state), 1);

    // Auto mode with constant input below the level.
    mode = 2'd1;
    for (int i = 1; i < 4096; i++) smp(-16'sd1000);
    chk("auto_before_timeout", 32'(state), 1);
`ifdef TRIG_AUTO_EN
    push_strobe(0, -16'sd1000);
    smp(-16'sd1000);
    chk("auto_capture", 32'(state), 2);
    chk("auto_flag_set", 32'(auto_fired), 1);
    for (int i = 1; i < 256; i++) begin
      push_strobe(i, -16'sd1000);
      smp(-16'sd1000);
    end
    chk("auto_wait", 32'(state), 3);
`else
    smp(-16'sd1000);
    smp(-16'sd1000);
    chk("auto_absent_no_capture", 32'(state), 1);
    chk("auto_flag_tied", 32'(auto_fired), 0);
`endif
    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
